// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory write port.
interface dmem_arbiter_if #(
    parameter int unsigned S = 32,
    parameter int unsigned V = 192
);
    logic         c_req;
    logic         c_we;
    logic         c_vec;
    logic [S-1:0] c_addr;
    logic [V-1:0] c_wd;
    logic         c_gnt;
    logic         c_done;

    logic         l_req;
    logic         l_we;
    logic         l_vec;
    logic [S-1:0] l_addr;
    logic [V-1:0] l_wd;
    logic         l_gnt;
    logic         l_done;

    logic         mem_we;
    logic [S-1:0] mem_addr;
    logic [S-1:0] mem_wd;
    logic         mem_isVector;
    logic         busy;
    logic         err_oob;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_vec, c_addr, c_wd,
        input  l_req, l_we, l_vec, l_addr, l_wd,
        output c_gnt, c_done, l_gnt, l_done,
        output mem_we, mem_addr, mem_wd, mem_isVector, busy, err_oob
    );

    // Requester / memory side
    modport master (
        output c_req, c_we, c_vec, c_addr, c_wd,
        output l_req, l_we, l_vec, l_addr, l_wd,
        input  c_gnt, c_done, l_gnt, l_done,
        input  mem_we, mem_addr, mem_wd, mem_isVector, busy, err_oob
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory write port; serializes vector
// accesses into single-word beats and rejects out-of-bounds requests.
module dmem_arbiter #(
    parameter int unsigned S     = 32,
    parameter int unsigned V     = 192,
    parameter int unsigned LANES = 6,
    parameter int unsigned SIZE  = 30015
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned BW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SW = S + 1;
    localparam int unsigned RW = V - S;

    typedef enum logic [1:0] {IDLE, XFER, DONE, REJECT} state_t;

    state_t        state;
    logic [BW-1:0] beat;
    logic          owner_l;
    logic          vec_q;
    logic [RW-1:0] wd_q;

    logic          pick_l;
    logic          sel_we;
    logic          sel_vec;
    logic [S-1:0]  sel_addr;
    logic [V-1:0]  sel_wd;
    logic [SW-1:0] sel_last;
    logic          oob;
    logic          last_beat;

    // Winner selection and bounds check for the request sampled in IDLE
    always_comb begin
        pick_l    = bus.l_req && (!bus.c_req || !owner_l);
        sel_we    = pick_l ? bus.l_we   : bus.c_we;
        sel_vec   = pick_l ? bus.l_vec  : bus.c_vec;
        sel_addr  = pick_l ? bus.l_addr : bus.c_addr;
        sel_wd    = pick_l ? bus.l_wd   : bus.c_wd;
        sel_last  = {1'b0, sel_addr} + SW'(sel_vec ? LANES - 1 : 0);
        oob       = sel_last >= SW'(SIZE);
        last_beat = vec_q ? (beat == BW'(LANES - 1)) : (beat == '0);
    end

    assign bus.mem_isVector = 1'b0;

    // Remaining words shift down through wd_q so each beat reads the low word
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            owner_l      <= 1'b1;
            vec_q        <= 1'b0;
            wd_q         <= '0;
            bus.c_gnt    <= 1'b0;
            bus.c_done   <= 1'b0;
            bus.l_gnt    <= 1'b0;
            bus.l_done   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wd   <= '0;
            bus.busy     <= 1'b0;
            bus.err_oob  <= 1'b0;
        end else begin
            bus.c_gnt   <= 1'b0;
            bus.l_gnt   <= 1'b0;
            bus.c_done  <= 1'b0;
            bus.l_done  <= 1'b0;
            bus.err_oob <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.c_req || bus.l_req) begin
                        owner_l   <= pick_l;
                        vec_q     <= sel_vec;
                        wd_q      <= sel_wd[V-1:S];
                        beat      <= '0;
                        bus.busy  <= 1'b1;
                        bus.c_gnt <= !pick_l;
                        bus.l_gnt <= pick_l;
                        if (oob) begin
                            state       <= REJECT;
                            bus.c_done  <= !pick_l;
                            bus.l_done  <= pick_l;
                            bus.err_oob <= 1'b1;
                            bus.mem_we  <= 1'b0;
                        end else begin
                            state        <= XFER;
                            bus.mem_we   <= sel_we;
                            bus.mem_addr <= sel_addr;
                            bus.mem_wd   <= sel_wd[S-1:0];
                        end
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        state      <= DONE;
                        bus.mem_we <= 1'b0;
                        bus.c_done <= !owner_l;
                        bus.l_done <= owner_l;
                    end else begin
                        beat         <= beat + BW'(1);
                        bus.mem_addr <= bus.mem_addr + S'(1);
                        bus.mem_wd   <= wd_q[S-1:0];
                        wd_q         <= wd_q >> S;
                    end
                end
                DONE, REJECT: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of transactions plus fairness and
// reset-mid-operation sequences, with a small negedge-write memory model.
module tb_dmem_arbiter;
    localparam int unsigned S     = 32;
    localparam int unsigned V     = 192;
    localparam int unsigned LANES = 6;
    localparam int unsigned SIZE  = 30015;
    localparam int unsigned MDEP  = 1024;

    typedef struct {
        string       name;
        logic        is_l;
        logic        we;
        logic        vec;
        logic [31:0] addr;
        logic [31:0] base;
        logic [31:0] step;
        int          beats;
        logic        oob;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] tb_mem [MDEP];

    dmem_arbiter_if #(.S(S), .V(V)) bus ();

    dmem_arbiter #(.S(S), .V(V), .LANES(LANES), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory writes on the falling edge
    always @(negedge clk) begin
        if (bus.mem_we && bus.mem_addr < MDEP)
            tb_mem[bus.mem_addr[9:0]] <= bus.mem_wd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_c_gnt"},  32'(bus.c_gnt),  0);
        chk({nm, "_c_done"}, 32'(bus.c_done), 0);
        chk({nm, "_l_gnt"},  32'(bus.l_gnt),  0);
        chk({nm, "_l_done"}, 32'(bus.l_done), 0);
        chk({nm, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({nm, "_addr"},   bus.mem_addr,    0);
        chk({nm, "_wd"},     bus.mem_wd,      0);
        chk({nm, "_busy"},   32'(bus.busy),   0);
        chk({nm, "_oob"},    32'(bus.err_oob), 0);
        chk({nm, "_isvec"},  32'(bus.mem_isVector), 0);
    endtask

    task automatic clear_reqs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_vec = 1'b0; bus.c_addr = '0; bus.c_wd = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_vec = 1'b0; bus.l_addr = '0; bus.l_wd = '0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        step();
        step();
        chk_all_zero(nm);
        rst = 1'b0;
    endtask

    task automatic drive_req(input txn_t t);
        logic [V-1:0] wd;
        wd = '0;
        for (int k = 0; k < int'(LANES); k++)
            wd[k*S +: S] = t.base + 32'(k) * t.step;
        if (t.is_l) begin
            bus.l_req = 1'b1; bus.l_we = t.we; bus.l_vec = t.vec; bus.l_addr = t.addr; bus.l_wd = wd;
        end else begin
            bus.c_req = 1'b1; bus.c_we = t.we; bus.c_vec = t.vec; bus.c_addr = t.addr; bus.c_wd = wd;
        end
    endtask

    task automatic run_txn(input txn_t t);
        logic g, o_g, d;
        drive_req(t);
        step();
        if (t.oob) begin
            g = t.is_l ? bus.l_gnt  : bus.c_gnt;
            d = t.is_l ? bus.l_done : bus.c_done;
            chk({t.name, "_rej_gnt"},  32'(g), 1);
            chk({t.name, "_rej_done"}, 32'(d), 1);
            chk({t.name, "_rej_oob"},  32'(bus.err_oob), 1);
            chk({t.name, "_rej_we"},   32'(bus.mem_we), 0);
            clear_reqs();
            step();
            chk({t.name, "_rej_end"}, {29'd0, bus.err_oob, bus.c_done | bus.l_done, bus.busy}, 0);
            chk({t.name, "_rej_we2"}, 32'(bus.mem_we), 0);
        end else begin
            for (int k = 0; k < t.beats; k++) begin
                g   = t.is_l ? bus.l_gnt : bus.c_gnt;
                o_g = t.is_l ? bus.c_gnt : bus.l_gnt;
                chk($sformatf("%s_gnt%0d", t.name, k),  32'(g), (k == 0) ? 1 : 0);
                chk($sformatf("%s_ogn%0d", t.name, k),  32'(o_g), 0);
                chk($sformatf("%s_we%0d", t.name, k),   32'(bus.mem_we), 32'(t.we));
                chk($sformatf("%s_addr%0d", t.name, k), bus.mem_addr, t.addr + 32'(k));
                chk($sformatf("%s_wd%0d", t.name, k),   bus.mem_wd, t.base + 32'(k) * t.step);
                chk($sformatf("%s_vec%0d", t.name, k),  32'(bus.mem_isVector), 0);
                chk($sformatf("%s_dn%0d", t.name, k),   32'(bus.c_done | bus.l_done), 0);
                chk($sformatf("%s_bsy%0d", t.name, k),  32'(bus.busy), 1);
                if (k == 0) clear_reqs();
                step();
            end
            d = t.is_l ? bus.l_done : bus.c_done;
            chk({t.name, "_done"},    32'(d), 1);
            chk({t.name, "_done_we"}, 32'(bus.mem_we), 0);
            chk({t.name, "_done_oob"}, 32'(bus.err_oob), 0);
            step();
            chk({t.name, "_idle"}, {30'd0, bus.busy, bus.c_done | bus.l_done}, 0);
        end
    endtask

    initial begin
        txn_t tbl[7];
        int   gcyc[$];
        bit   gport[$];

        for (int i = 0; i < int'(MDEP); i++) tb_mem[i] = '0;
        clear_reqs();

        tbl[0] = '{"c_scalar_wr", 1'b0, 1'b1, 1'b0, 32'd100,        32'hDEADBEEF, 32'h0,  1, 1'b0};
        tbl[1] = '{"l_vector_wr", 1'b1, 1'b1, 1'b1, 32'd600,        32'h11,       32'h11, 6, 1'b0};
        tbl[2] = '{"c_vec_oob",   1'b0, 1'b1, 1'b1, 32'd30010,      32'h5,        32'h1,  0, 1'b1};
        tbl[3] = '{"c_wrap",      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF,   32'h7,        32'h0,  0, 1'b1};
        tbl[4] = '{"l_probe_top", 1'b1, 1'b0, 1'b0, 32'd30014,      32'h1234,     32'h0,  1, 1'b0};
        tbl[5] = '{"c_vec_edge",  1'b0, 1'b1, 1'b1, 32'd30009,      32'h100,      32'h3,  6, 1'b0};
        tbl[6] = '{"l_vec_oob",   1'b1, 1'b0, 1'b1, 32'd30010,      32'h9,        32'h1,  0, 1'b1};

        do_reset("reset0");
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        chk("mem_100", tb_mem[100], 32'hDEADBEEF);
        for (int k = 0; k < 6; k++)
            chk($sformatf("mem_%0d", 600 + k), tb_mem[600 + k], 32'h11 * 32'(k + 1));

        // Fairness: both ports hold scalar requests from reset
        do_reset("reset1");
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'd10; bus.c_wd = 192'hC;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'd20; bus.l_wd = 192'hD;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            chk($sformatf("both_gnt_c%0d", cyc), 32'(bus.c_gnt & bus.l_gnt), 0);
            if (bus.c_gnt || bus.l_gnt) begin
                gcyc.push_back(cyc);
                gport.push_back(bus.l_gnt);
            end
            if (gcyc.size() == 4) clear_reqs();
        end
        chk("fair_count", 32'(gcyc.size()), 4);
        if (gcyc.size() == 4) begin
            chk("fair_first", 32'(gcyc[0]), 1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("fair_port%0d", i), 32'(gport[i]), 32'(i % 2));
                if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 3);
            end
        end

        // Reset during beat 3 of a vector write at address 0
        do_reset("reset2");
        for (int k = 0; k < 6; k++) tb_mem[k] = '0;
        begin
            txn_t t;
            t = '{"mid_rst", 1'b0, 1'b1, 1'b1, 32'd0, 32'hA0, 32'h1, 6, 1'b0};
            drive_req(t);
        end
        step();
        chk("midrst_gnt", 32'(bus.c_gnt), 1);
        clear_reqs();
        step();
        step();
        step();
        chk("midrst_beat3_addr", bus.mem_addr, 3);
        chk("midrst_beat3_wd", bus.mem_wd, 32'hA3);
        rst = 1'b1;
        step();
        chk_all_zero("midrst_after");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst_nodone%0d", i), {30'd0, bus.c_done, bus.mem_we}, 0);
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("midrst_mem%0d", k), tb_mem[k], 32'hA0 + 32'(k));
        chk("midrst_mem4", tb_mem[4], 0);
        chk("midrst_mem5", tb_mem[5], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
